// File: rtl/ram_addr_sequencer.sv
// Strided RAM read sequencer: issues COUNT reads from base by stride and
// streams the returned words out through a 2-entry valid/ready FIFO.
module ram_addr_sequencer #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CNT_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] stride,
    input  logic [CNT_W-1:0]  count,
    output logic              ram_en,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state;
    logic [ADDR_W-1:0]  stride_q;
    logic [CNT_W-1:0]   count_q;
    logic [CNT_W-1:0]   issued;
    logic [CNT_W-1:0]   accepted;
    logic               inflight;
    logic [DATA_W-1:0]  tail_data;
    logic               tail_valid;

    logic               pop;
    logic [1:0]         occ_after_pop;
    logic               credit_ok;

    // A word leaving this cycle frees its slot, so reads can run back-to-back.
    always_comb begin
        pop           = out_valid && out_ready;
        occ_after_pop = 2'(out_valid) + 2'(tail_valid) - 2'(pop);
        credit_ok     = (occ_after_pop + 2'(inflight)) <= 2'd1;
        ram_en        = (state == ISSUE) && (issued < count_q) && credit_ok;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            ram_addr   <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            stride_q   <= '0;
            count_q    <= '0;
            issued     <= '0;
            accepted   <= '0;
            inflight   <= 1'b0;
            tail_data  <= '0;
            tail_valid <= 1'b0;
        end else begin
            inflight <= ram_en;
            done     <= 1'b0;

            // Output FIFO: head register (out_data) plus one tail entry.
            if (inflight) begin
                if (!out_valid) begin
                    out_data  <= ram_rdata;
                    out_valid <= 1'b1;
                end else if (pop) begin
                    if (tail_valid) begin
                        out_data  <= tail_data;
                        tail_data <= ram_rdata;
                    end else begin
                        out_data <= ram_rdata;
                    end
                end else begin
                    tail_data  <= ram_rdata;
                    tail_valid <= 1'b1;
                end
            end else if (pop) begin
                if (tail_valid) begin
                    out_data   <= tail_data;
                    tail_valid <= 1'b0;
                end else begin
                    out_valid <= 1'b0;
                end
            end

            if (pop) begin
                accepted <= accepted + CNT_W'(1);
            end

            if (ram_en) begin
                issued   <= issued + CNT_W'(1);
                ram_addr <= ram_addr + stride_q;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        if (count != '0) begin
                            state    <= ISSUE;
                            busy     <= 1'b1;
                            ram_addr <= base_addr;
                            stride_q <= stride;
                            count_q  <= count;
                            issued   <= '0;
                            accepted <= '0;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (ram_en && (issued + CNT_W'(1) == count_q)) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (pop && (accepted + CNT_W'(1) == count_q)) begin
                        state <= DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
